// File: rtl/scx_slave_arbiter_if.sv
// Bus bundle between NREQ SCx requesters, the slave arbiter and the single SCx slave-wrapper port.
// The arbiter takes the slave modport; the requesters and downstream wrapper together form the master side.
interface scx_slave_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      M_REQ;
    logic [NREQ-1:0]      M_WT;
    logic [4*NREQ-1:0]    M_BE;
    logic [32*NREQ-1:0]   M_ADDR;
    logic [32*NREQ-1:0]   M_WDT;
    logic [NREQ-1:0]      M_nWAIT;
    logic [NREQ-1:0]      M_FAULT;
    logic [31:0]          M_RDT;

    logic                 SCx_REQ;
    logic                 SCx_WT;
    logic [3:0]           SCx_BE;
    logic [31:0]          SCx_ADDR;
    logic [31:0]          SCx_WDT;
    logic                 SCx_nWAIT;
    logic                 SCx_FAULT;
    logic                 SCx_TimeOut;
    logic [31:0]          SCx_RDT;

    modport slave (
        input  M_REQ, M_WT, M_BE, M_ADDR, M_WDT,
        output M_nWAIT, M_FAULT, M_RDT,
        output SCx_REQ, SCx_WT, SCx_BE, SCx_ADDR, SCx_WDT,
        input  SCx_nWAIT, SCx_FAULT, SCx_TimeOut, SCx_RDT
    );

    modport master (
        output M_REQ, M_WT, M_BE, M_ADDR, M_WDT,
        input  M_nWAIT, M_FAULT, M_RDT,
        input  SCx_REQ, SCx_WT, SCx_BE, SCx_ADDR, SCx_WDT,
        output SCx_nWAIT, SCx_FAULT, SCx_TimeOut, SCx_RDT
    );
endinterface

// File: rtl/scx_slave_arbiter.sv
// Round-robin arbiter sharing one SCx slave-wrapper port between NREQ requesters.
// Define SCX_ARB_WDOG_EN to add a watchdog that force-completes a stalled transfer with a fault.
module scx_slave_arbiter #(
    parameter int NREQ        = 2,
    parameter int IDW         = 1,
    parameter int WDOG_CYCLES = 255,
    parameter int WDOG_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    scx_slave_arbiter_if.slave   bus,
    output logic                 o_GNT_VALID,
    output logic [IDW-1:0]       o_GNT_ID
);

    typedef enum logic {
        ST_ARB_IDLE,
        ST_ARB_BUSY
    } arbState_t;

    arbState_t          r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_gntId;
    logic               r_gntValid;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic               w_busy;
    logic               w_req;
    logic               w_wt;
    logic [3:0]         w_be;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdt;
    logic               w_wdogHit;
    logic               w_done;
    logic               w_fault;

    if ((NREQ < 2) || (NREQ > 8) || (IDW != $clog2(NREQ)) || ((2 ** WDOG_W) <= WDOG_CYCLES)) begin : g_paramCheck
        $error("scx_slave_arbiter: inconsistent NREQ/IDW/WDOG_CYCLES/WDOG_W");
    end

    // First pass finds a requester at or after ptr; second pass wraps to the lowest index.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.M_REQ[i] && (IDW'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.M_REQ[i]) begin
                w_found  = 1'b1;
                w_winner = IDW'(i);
            end
        end
    end

    always_comb begin
        w_req  = 1'b0;
        w_wt   = 1'b0;
        w_be   = '0;
        w_addr = '0;
        w_wdt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gntId == IDW'(i)) begin
                w_req  = bus.M_REQ[i];
                w_wt   = bus.M_WT[i];
                w_be   = bus.M_BE[4*i +: 4];
                w_addr = bus.M_ADDR[32*i +: 32];
                w_wdt  = bus.M_WDT[32*i +: 32];
            end
        end
    end

`ifdef SCX_ARB_WDOG_EN
    logic [WDOG_W-1:0]  r_wdogCnt;
    assign w_wdogHit = w_busy && w_req && (r_wdogCnt == WDOG_W'(WDOG_CYCLES));
`else
    assign w_wdogHit = 1'b0;
`endif

    // A pending synchronous reset suppresses any completion in its cycle.
    assign w_busy  = (r_state == ST_ARB_BUSY) && !RST;
    assign w_done  = w_busy && w_req && (bus.SCx_nWAIT || bus.SCx_TimeOut || w_wdogHit);
    assign w_fault = bus.SCx_FAULT || bus.SCx_TimeOut || w_wdogHit;

    assign bus.SCx_REQ  = w_busy && w_req && !w_wdogHit;
    assign bus.SCx_WT   = w_busy && w_wt;
    assign bus.SCx_BE   = w_busy ? w_be   : '0;
    assign bus.SCx_ADDR = w_busy ? w_addr : '0;
    assign bus.SCx_WDT  = w_busy ? w_wdt  : '0;
    assign bus.M_RDT    = w_busy ? bus.SCx_RDT : '0;

    always_comb begin
        bus.M_nWAIT = '0;
        bus.M_FAULT = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_done && (r_gntId == IDW'(i))) begin
                bus.M_nWAIT[i] = 1'b1;
                bus.M_FAULT[i] = w_fault;
            end
        end
    end

    // An abort (request dropped before completion) returns to idle without moving ptr.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_ARB_IDLE;
            r_ptr      <= '0;
            r_gntId    <= '0;
            r_gntValid <= 1'b0;
`ifdef SCX_ARB_WDOG_EN
            r_wdogCnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_ARB_IDLE: begin
                    if (w_found) begin
                        r_gntId    <= w_winner;
                        r_gntValid <= 1'b1;
                        r_state    <= ST_ARB_BUSY;
                    end
                end
                ST_ARB_BUSY: begin
                    if (w_done) begin
                        r_state    <= ST_ARB_IDLE;
                        r_gntValid <= 1'b0;
                        r_ptr      <= (r_gntId == IDW'(NREQ - 1)) ? '0 : r_gntId + 1'b1;
                    end else if (!w_req) begin
                        r_state    <= ST_ARB_IDLE;
                        r_gntValid <= 1'b0;
                    end
                end
            endcase
`ifdef SCX_ARB_WDOG_EN
            if (r_state == ST_ARB_IDLE) begin
                r_wdogCnt <= '0;
            end else if (!w_done) begin
                r_wdogCnt <= r_wdogCnt + 1'b1;
            end
`endif
        end
    end

    assign o_GNT_VALID = r_gntValid;
    assign o_GNT_ID    = r_gntId;

endmodule

// File: tb/tb_scx_slave_arbiter.sv
// Bench for scx_slave_arbiter: directed vector table, round-robin and watchdog sequences,
// then random traffic compared every cycle against a transfer-level reference model.
module tb_scx_slave_arbiter;
    localparam int NREQ        = 3;
    localparam int IDW         = 2;
    localparam int WDOG_CYCLES = 8;
    localparam int WDOG_W      = 4;
    localparam int OW          = 111;
    localparam int NVEC        = 26;

    localparam logic [NREQ-1:0]    P_WT   = 3'b010;
    localparam logic [4*NREQ-1:0]  P_BE   = 12'hFCF;
    localparam logic [32*NREQ-1:0] P_ADDR = {32'h3000_0008, 32'h2000_0000, 32'h1000_0040};
    localparam logic [32*NREQ-1:0] P_WDT  = {32'hCAFE_0002, 32'h1234_5678, 32'hCAFE_0000};

    typedef struct {
        logic             rst;
        logic [NREQ-1:0]  req;
        logic             nWait;
        logic             tOut;
        logic             fault;
        logic [31:0]      rdt;
        logic [OW-1:0]    exp;
    } vec_t;

    logic               CLK = 1'b0;
    logic               tRst;
    logic [NREQ-1:0]    tReq;
    logic [NREQ-1:0]    tWt;
    logic [4*NREQ-1:0]  tBe;
    logic [32*NREQ-1:0] tAddr;
    logic [32*NREQ-1:0] tWdt;
    logic               tNwait;
    logic               tTout;
    logic               tFault;
    logic [31:0]        tRdt;
    logic               gntValid;
    logic [IDW-1:0]     gntId;

    int nChecks = 0;
    int nPass   = 0;
    bit chkEn   = 1'b0;

    bit              mBusy = 1'b0;
    int              mGnt = 0;
    int              mPtr = 0;
    int              mCycles = 0;
    int              mIdx;
    logic            mActive, mReqG, mWdHit, mDone;
    logic [NREQ-1:0] mNw, mFt;
    logic [NREQ-1:0] mLastNwait = '0;
    logic [OW-1:0]   mExp;

    vec_t vecs [NVEC];

    scx_slave_arbiter_if #(.NREQ(NREQ)) bus ();

    assign bus.M_REQ       = tReq;
    assign bus.M_WT        = tWt;
    assign bus.M_BE        = tBe;
    assign bus.M_ADDR      = tAddr;
    assign bus.M_WDT       = tWdt;
    assign bus.SCx_nWAIT   = tNwait;
    assign bus.SCx_TimeOut = tTout;
    assign bus.SCx_FAULT   = tFault;
    assign bus.SCx_RDT     = tRdt;

    scx_slave_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .WDOG_CYCLES(WDOG_CYCLES), .WDOG_W(WDOG_W)
    ) dut (
        .CLK(CLK),
        .RST(tRst),
        .bus(bus),
        .o_GNT_VALID(gntValid),
        .o_GNT_ID(gntId)
    );

    always #5 CLK = ~CLK;

    function automatic logic [OW-1:0] packOut(input logic req, input logic wt, input logic [3:0] be,
                                              input logic [31:0] addr, input logic [31:0] wdt,
                                              input logic [NREQ-1:0] nw, input logic [NREQ-1:0] ft,
                                              input logic [31:0] rdt, input logic gv, input logic [IDW-1:0] gid);
        return {req, wt, be, addr, wdt, nw, ft, rdt, gv, gid};
    endfunction

    function automatic logic [OW-1:0] dutOut();
        return packOut(bus.SCx_REQ, bus.SCx_WT, bus.SCx_BE, bus.SCx_ADDR, bus.SCx_WDT,
                       bus.M_nWAIT, bus.M_FAULT, bus.M_RDT, gntValid, gntId);
    endfunction

    function automatic logic [OW-1:0] expBusy(input int gid, input logic req, input logic [NREQ-1:0] nw,
                                              input logic [NREQ-1:0] ft, input logic [31:0] rdt);
        return packOut(req, P_WT[gid], P_BE[4*gid +: 4], P_ADDR[32*gid +: 32], P_WDT[32*gid +: 32],
                       nw, ft, rdt, 1'b1, IDW'(gid));
    endfunction

    function automatic logic [OW-1:0] expIdle(input int gid);
        return packOut(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, '0, '0, 32'h0, 1'b0, IDW'(gid));
    endfunction

    function automatic vec_t mkVec(input logic rst, input logic [NREQ-1:0] req, input logic nWait,
                                   input logic tOut, input logic fault, input logic [31:0] rdt,
                                   input logic [OW-1:0] exp);
        vec_t v;
        v.rst = rst; v.req = req; v.nWait = nWait; v.tOut = tOut;
        v.fault = fault; v.rdt = rdt; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge CLK);
        #1;
        tRst   = v.rst;
        tReq   = v.req;
        tNwait = v.nWait;
        tTout  = v.tOut;
        tFault = v.fault;
        tRdt   = v.rdt;
    endtask

    task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        nChecks++;
        if (act === req) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: one granted transfer at a time, round-robin from the slot after the last completion.
    initial begin
        forever begin
            @(negedge CLK);
            mActive = mBusy && !tRst;
            mReqG   = mBusy && tReq[mGnt];
`ifdef SCX_ARB_WDOG_EN
            mWdHit  = mActive && mReqG && (mCycles == WDOG_CYCLES + 1);
`else
            mWdHit  = 1'b0;
`endif
            mDone   = mActive && mReqG && (tNwait || tTout || mWdHit);
            mNw = '0;
            mFt = '0;
            if (mDone) begin
                mNw[mGnt] = 1'b1;
                mFt[mGnt] = tFault || tTout || mWdHit;
            end
            if (mActive) begin
                mExp = packOut(mReqG && !mWdHit, tWt[mGnt], tBe[4*mGnt +: 4], tAddr[32*mGnt +: 32],
                               tWdt[32*mGnt +: 32], mNw, mFt, tRdt, 1'b1, IDW'(mGnt));
            end else begin
                mExp = packOut(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, '0, '0, 32'h0, mBusy, IDW'(mGnt));
            end
            if (chkEn) begin
                checkOutput("model", dutOut(), mExp);
            end
            mLastNwait = mNw;
            if (tRst) begin
                mBusy = 1'b0; mPtr = 0; mGnt = 0; mCycles = 0;
            end else if (!mBusy) begin
                for (int k = 0; k < NREQ; k++) begin
                    mIdx = (mPtr + k) % NREQ;
                    if (!mBusy && tReq[mIdx]) begin
                        mBusy = 1'b1; mGnt = mIdx; mCycles = 1;
                    end
                end
            end else if (mDone) begin
                mBusy = 1'b0;
                mPtr  = (mGnt + 1) % NREQ;
            end else if (!mReqG) begin
                mBusy = 1'b0;
            end else begin
                mCycles++;
            end
        end
    end

    initial begin
        tRst = 1'b1; tReq = '0; tWt = P_WT; tBe = P_BE; tAddr = P_ADDR; tWdt = P_WDT;
        tNwait = 1'b0; tTout = 1'b0; tFault = 1'b0; tRdt = 32'h0;
        repeat (3) @(posedge CLK);
        chkEn = 1'b1;

        vecs[0]  = mkVec(1, 3'b000, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[1]  = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[2]  = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[3]  = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[4]  = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[5]  = mkVec(0, 3'b001, 1, 0, 0, 32'hDEAD_BEEF, expBusy(0, 1, 3'b001, 3'b000, 32'hDEAD_BEEF));
        vecs[6]  = mkVec(0, 3'b011, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[7]  = mkVec(0, 3'b011, 0, 0, 0, 32'h0,         expBusy(1, 1, 3'b000, 3'b000, 32'h0));
        vecs[8]  = mkVec(0, 3'b011, 1, 0, 0, 32'h5555_AAAA, expBusy(1, 1, 3'b010, 3'b000, 32'h5555_AAAA));
        vecs[9]  = mkVec(0, 3'b001, 0, 1, 0, 32'h0,         expIdle(1));
        vecs[10] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[11] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[12] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[13] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[14] = mkVec(0, 3'b001, 0, 1, 0, 32'h0,         expBusy(0, 1, 3'b001, 3'b001, 32'h0));
        vecs[15] = mkVec(0, 3'b100, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[16] = mkVec(0, 3'b100, 1, 0, 1, 32'h0,         expBusy(2, 1, 3'b100, 3'b100, 32'h0));
        vecs[17] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expIdle(2));
        vecs[18] = mkVec(0, 3'b001, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[19] = mkVec(0, 3'b000, 0, 0, 0, 32'h0,         expBusy(0, 0, 3'b000, 3'b000, 32'h0));
        vecs[20] = mkVec(0, 3'b000, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[21] = mkVec(0, 3'b101, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[22] = mkVec(0, 3'b101, 0, 0, 0, 32'h0,         expBusy(0, 1, 3'b000, 3'b000, 32'h0));
        vecs[23] = mkVec(1, 3'b101, 1, 0, 0, 32'h0,
                         packOut(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, '0, '0, 32'h0, 1'b1, 2'd0));
        vecs[24] = mkVec(0, 3'b000, 0, 0, 0, 32'h0,         expIdle(0));
        vecs[25] = mkVec(0, 3'b000, 0, 0, 0, 32'h0,         expIdle(0));

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge CLK);
            checkOutput($sformatf("vec%0d", i), dutOut(), vecs[i].exp);
        end

        // Both low requesters always pending with instant completion: grants must alternate.
        applyStimulus(mkVec(1, 3'b000, 0, 0, 0, 32'h0, '0));
        for (int c = 0; c < 8; c++) begin
            applyStimulus(mkVec(0, 3'b011, 1, 0, 0, 32'h0, '0));
            @(negedge CLK);
            if (c % 2 == 0) begin
                checkOutput("rrIdle", OW'({gntValid, bus.M_nWAIT}), OW'({1'b0, 3'b000}));
            end else begin
                checkOutput("rrGrant", OW'({gntValid, gntId, bus.M_nWAIT}),
                            OW'({1'b1, IDW'((c / 2) % 2), NREQ'(1 << ((c / 2) % 2))}));
            end
        end

        // Downstream never answers.
        applyStimulus(mkVec(1, 3'b000, 0, 0, 0, 32'h0, '0));
        applyStimulus(mkVec(0, 3'b001, 0, 0, 0, 32'h0, '0));
`ifdef SCX_ARB_WDOG_EN
        for (int k = 1; k <= WDOG_CYCLES + 1; k++) begin
            applyStimulus(mkVec(0, 3'b001, 0, 0, 0, 32'h0, '0));
            @(negedge CLK);
            if (k <= WDOG_CYCLES) begin
                checkOutput("wdogHold", OW'({gntValid, bus.SCx_REQ, bus.M_nWAIT, bus.M_FAULT}),
                            OW'({1'b1, 1'b1, 3'b000, 3'b000}));
            end else begin
                checkOutput("wdogFire", OW'({gntValid, bus.SCx_REQ, bus.M_nWAIT, bus.M_FAULT}),
                            OW'({1'b1, 1'b0, 3'b001, 3'b001}));
            end
        end
        applyStimulus(mkVec(0, 3'b000, 0, 0, 0, 32'h0, '0));
        @(negedge CLK);
        checkOutput("wdogIdle", OW'({gntValid, bus.M_nWAIT}), OW'({1'b0, 3'b000}));
`else
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(mkVec(0, 3'b001, 0, 0, 0, 32'h0, '0));
            @(negedge CLK);
            checkOutput("stallHold", OW'({gntValid, bus.SCx_REQ, bus.M_nWAIT, bus.M_FAULT}),
                        OW'({1'b1, 1'b1, 3'b000, 3'b000}));
        end
        applyStimulus(mkVec(0, 3'b000, 0, 0, 0, 32'h0, '0));
        @(negedge CLK);
        checkOutput("stallAbort", OW'({gntValid, bus.SCx_REQ, bus.M_nWAIT}), OW'({1'b1, 1'b0, 3'b000}));
`endif

        // Random traffic: requesters hold until completion, occasionally abort; SCx side randomised.
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            #1;
            tRst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!tReq[i] || mLastNwait[i]) begin
                    tReq[i]           = ($urandom_range(0, 2) == 0);
                    tWt[i]            = 1'($urandom_range(0, 1));
                    tBe[4*i +: 4]     = 4'($urandom);
                    tAddr[32*i +: 32] = $urandom;
                    tWdt[32*i +: 32]  = $urandom;
                end else if ($urandom_range(0, 39) == 0) begin
                    tReq[i] = 1'b0;
                end
            end
            tNwait = ($urandom_range(0, 2) == 0);
            tTout  = ($urandom_range(0, 19) == 0);
            tFault = 1'($urandom_range(0, 1));
            tRdt   = $urandom;
        end

        @(posedge CLK);
        #1;
        chkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/scx_slave_arbiter.md
Name: scx_slave_arbiter

Overview:
- Round-robin arbiter that shares one SCx slave-wrapper port between NREQ requesters, for example the external-interface receiver and an on-chip DMA or debug master.
- Forwards the granted requester's WT/BE/ADDR/WDT to the single SCx port.
- Returns nWAIT, FAULT and read data to the granted requester only, and holds every other requester in wait.
- Converts SCx_TimeOut, and an optional internal watchdog expiry, into a faulted completion so that no requester hangs.

Parameters:
NREQ, 2, number of requester ports (2..8)
IDW, 1, width of grant index; must equal clog2(NREQ), minimum 1
WDOG_CYCLES, 255, watchdog limit in CLK cycles (used only with ARB_WDOG_EN)
WDOG_W, 8, watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
M_REQ  in  NREQ  per-requester transfer request; held high until completion
M_WT  in  NREQ  per-requester write(1)/read(0)
M_BE  in  4*NREQ  byte enables; requester i uses bits [4i+3:4i]
M_ADDR  in  32*NREQ  addresses; requester i uses bits [32i+31:32i]
M_WDT  in  32*NREQ  write data, same packing as M_ADDR
M_nWAIT  out  NREQ  per-requester completion strobe (1 = transfer done this cycle)
M_FAULT  out  NREQ  per-requester fault, valid only when the matching M_nWAIT=1
M_RDT  out  32  read data broadcast to all requesters, valid for the requester whose M_nWAIT=1
SCx_REQ  out  1  downstream request
SCx_WT  out  1  downstream write/read
SCx_BE  out  4  downstream byte enables
SCx_ADDR  out  32  downstream address
SCx_WDT  out  32  downstream write data
SCx_nWAIT  in  1  downstream ready/complete
SCx_FAULT  in  1  downstream fault
SCx_TimeOut  in  1  downstream timeout
SCx_RDT  in  32  downstream read data
GNT_VALID  out  1  grant active (registered)
GNT_ID  out  IDW  index of the granted requester (registered)

Behaviour:
- Reset:
  - State ST_ARB_IDLE, ptr=0, GNT_VALID=0, GNT_ID=0.
  - All outputs forced low, including M_nWAIT=0, M_FAULT=0, SCx_REQ=0 and SCx_WT=0.
  - SCx_BE/ADDR/WDT=0 and M_RDT=0.
- States: ST_ARB_IDLE, ST_ARB_BUSY.
- ST_ARB_IDLE:
  - If M_REQ != 0, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - On the next edge: GNT_ID<=winner, GNT_VALID<=1, state<=BUSY.
  - SCx_REQ=0 throughout IDLE.
- ST_ARB_BUSY, combinational mux on registered GNT_ID:
  - SCx_REQ = M_REQ[GNT_ID].
  - SCx_WT/BE/ADDR/WDT = slices of GNT_ID.
  - M_RDT = SCx_RDT.
- Completion:
  - Condition: BUSY, M_REQ[GNT_ID]=1, and (SCx_nWAIT=1 or SCx_TimeOut=1).
  - Same cycle: M_nWAIT[GNT_ID]=1, M_FAULT[GNT_ID] = SCx_FAULT | SCx_TimeOut.
  - Next edge: state<=IDLE, GNT_VALID<=0, ptr<=(GNT_ID+1) mod NREQ.
- Latency: request first seen in IDLE at cycle t; SCx_REQ high at t+1; earliest M_nWAIT at t+1. Every transfer includes one IDLE arbitration cycle, so peak throughput is 1 transfer per 2 cycles.
- Non-granted requesters always see M_nWAIT=0 and M_FAULT=0. M_nWAIT and M_FAULT outside a completion cycle are 0.
- Abort: if M_REQ[GNT_ID] falls in BUSY before completion, SCx_REQ falls the same cycle and the next edge returns to IDLE with ptr unchanged. No M_nWAIT is issued.
- SCx_TimeOut ignored in IDLE.
- ptr wraps NREQ-1 -> 0.
- Simultaneous requests: the lowest index at or after ptr wins. A requester asserting REQ while another is granted waits until the next IDLE.
- RST mid-transfer: immediate return to reset values on the next edge. No completion is issued.

Optional Feature:
- Macro: SCX_ARB_WDOG_EN.
- Enabled:
  - WDOG_W-bit counter cleared in IDLE and incremented each BUSY cycle without completion.
  - When the count reaches WDOG_CYCLES, force completion: M_nWAIT[GNT_ID]=1, M_FAULT[GNT_ID]=1, SCx_REQ=0 in that cycle, next edge to IDLE, ptr advanced.
- Disabled: no counter logic; only SCx_nWAIT or SCx_TimeOut complete a transfer.

Test Plan:
- Single read:
  - Stimulus: M_REQ=01, M_WT[0]=0, ADDR0=0x1000_0040, SCx_nWAIT high after 3 BUSY cycles, SCx_RDT=0xDEAD_BEEF.
  - Response: SCx_ADDR=0x1000_0040; M_nWAIT=01 exactly once; M_RDT=0xDEADBEEF; M_FAULT=00; ptr=1.
- Simultaneous requests:
  - Stimulus: M_REQ=11 from reset, each downstream transfer completes in 1 cycle.
  - Response: grant order 0,1,0,1; GNT_ID toggles; no M_nWAIT to a non-granted port.
- Write forwarding:
  - Stimulus: requester 1 write, BE=0xC, WDT=0x1234_5678, ADDR=0x2000_0000.
  - Response: downstream SCx_WT=1, SCx_BE=0xC, SCx_WDT=0x12345678, SCx_ADDR=0x20000000 for the whole BUSY phase.
- Timeout:
  - Stimulus: SCx_nWAIT=0, SCx_TimeOut pulses in BUSY cycle 5.
  - Response: M_nWAIT[gnt]=1 and M_FAULT[gnt]=1 in that cycle; IDLE next cycle.
- Abort and reset:
  - Stimulus: drop M_REQ[0] in BUSY.
  - Response: SCx_REQ=0 the same cycle; no M_nWAIT; ptr stays 0.
  - Stimulus: assert RST in BUSY.
  - Response: GNT_VALID=0 and SCx_REQ=0 after the next edge.
- Watchdog (SCX_ARB_WDOG_EN, WDOG_CYCLES=8):
  - Stimulus: SCx_nWAIT stuck at 0.
  - Response: M_nWAIT[gnt]=1 and M_FAULT[gnt]=1 on BUSY cycle 9; with the macro undefined the grant holds indefinitely.
